// File: rtl/obi_axi_pkg.sv
// obi_axi_pkg: AXI4 channel types, encodings and helpers shared by the OBI-to-AXI bridge
package obi_axi_pkg;
  localparam int unsigned ID_W = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned USER_W = 1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic {DIR_READ = 1'b0, DIR_WRITE = 1'b1} dir_e;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [ADDR_W-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    logic [USER_W-1:0] user;
  } axi_32_aw_chan_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [ADDR_W-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [USER_W-1:0] user;
  } axi_32_ar_chan_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic last;
    logic [USER_W-1:0] user;
  } axi_32_w_chan_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0] resp;
    logic [USER_W-1:0] user;
  } axi_32_b_chan_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DATA_W-1:0] data;
    logic [1:0] resp;
    logic last;
    logic [USER_W-1:0] user;
  } axi_32_r_chan_t;
  typedef struct packed {
    axi_32_aw_chan_t aw;
    logic aw_valid;
    axi_32_w_chan_t w;
    logic w_valid;
    logic b_ready;
    axi_32_ar_chan_t ar;
    logic ar_valid;
    logic r_ready;
  } axi_32_req_t;
  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    logic b_valid;
    axi_32_b_chan_t b;
    logic r_valid;
    axi_32_r_chan_t r;
  } axi_32_resp_t;
  function automatic logic [2:0] axsize(input int unsigned dw);
    return 3'($clog2(dw / 8));
  endfunction
endpackage

// File: rtl/obi_axi_wr_tracker.sv
// obi_axi_wr_tracker: tracks independent AW/W acceptance and grants a write once both are done
module obi_axi_wr_tracker (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic issue_i,
  input  logic aw_ready_i,
  input  logic w_ready_i,
  output logic aw_valid_o,
  output logic w_valid_o,
  output logic gnt_o
);
  logic aw_done_q, w_done_q, aw_ok, w_ok;
  assign aw_valid_o = issue_i & ~aw_done_q;
  assign w_valid_o = issue_i & ~w_done_q;
  assign aw_ok = aw_done_q | (aw_valid_o & aw_ready_i);
  assign w_ok = w_done_q | (w_valid_o & w_ready_i);
  assign gnt_o = issue_i & aw_ok & w_ok;
  // remember a channel accepted early; both flags drop when the write is granted
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      aw_done_q <= gnt_o ? 1'b0 : aw_ok;
      w_done_q <= gnt_o ? 1'b0 : w_ok;
    end
endmodule

// File: rtl/obi_axi_bridge.sv
// obi_axi_bridge: OBI to single-beat AXI4 manager bridge with in-order registered responses
module obi_axi_bridge
  import obi_axi_pkg::*;
#(
  parameter type axi_req_t = axi_32_req_t,
  parameter type axi_resp_t = axi_32_resp_t,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic obi_req_i,
  output logic obi_gnt_o,
  input  logic obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [ADDR_WIDTH-1:0] obi_addr_i,
  input  logic [DATA_WIDTH-1:0] obi_wdata_i,
  output logic obi_rvalid_o,
  output logic [DATA_WIDTH-1:0] obi_rdata_o,
  output logic obi_err_o,
  output axi_req_t axi_req_o,
  input  axi_resp_t axi_resp_i
);
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);
  logic [3:0] cnt_q, cnt_d;
  dir_e dir_q;
  logic issue_ok, ar_valid, aw_valid, w_valid, rd_gnt, wr_gnt, r_hs, b_hs, rsp_hs, dec;
  logic rvalid_q, err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic unused_ok;
  assign issue_ok = obi_req_i & (cnt_q < MAX_CNT) & ((cnt_q == '0) | (dir_q == dir_e'(obi_we_i)));
  assign ar_valid = issue_ok & ~obi_we_i;
  assign rd_gnt = ar_valid & axi_resp_i.ar_ready;
  assign obi_gnt_o = rd_gnt | wr_gnt;
  assign r_hs = axi_resp_i.r_valid;
  assign b_hs = axi_resp_i.b_valid;
  assign rsp_hs = r_hs | b_hs;
  assign dec = rsp_hs & (cnt_q != '0);
  assign cnt_d = (obi_gnt_o & ~dec) ? cnt_q + 4'd1 : (~obi_gnt_o & dec) ? cnt_q - 4'd1 : cnt_q;
  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o = rdata_q;
  assign obi_err_o = err_q;
  assign unused_ok = ^{axi_resp_i.b.id, axi_resp_i.b.user, axi_resp_i.b.resp[0], axi_resp_i.r.id,
                       axi_resp_i.r.last, axi_resp_i.r.user, axi_resp_i.r.resp[0]};
  obi_axi_wr_tracker u_wr (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .issue_i(issue_ok & obi_we_i),
    .aw_ready_i(axi_resp_i.aw_ready),
    .w_ready_i(axi_resp_i.w_ready),
    .aw_valid_o(aw_valid),
    .w_valid_o(w_valid),
    .gnt_o(wr_gnt)
  );
  // drive single-beat AXI requests straight from the held OBI request
  always_comb begin
    axi_req_o = '0;
    axi_req_o.aw.id = AXI_ID;
    axi_req_o.aw.addr = obi_addr_i;
    axi_req_o.aw.size = axsize(DATA_WIDTH);
    axi_req_o.aw.burst = BURST_INCR;
    axi_req_o.aw_valid = aw_valid;
    axi_req_o.w.data = obi_wdata_i;
    axi_req_o.w.strb = obi_be_i;
    axi_req_o.w.last = 1'b1;
    axi_req_o.w_valid = w_valid;
    axi_req_o.b_ready = 1'b1;
    axi_req_o.ar.id = AXI_ID;
    axi_req_o.ar.addr = obi_addr_i;
    axi_req_o.ar.size = axsize(DATA_WIDTH);
    axi_req_o.ar.burst = BURST_INCR;
    axi_req_o.ar_valid = ar_valid;
    axi_req_o.r_ready = 1'b1;
  end
  // outstanding count, current direction and the one-stage response register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q <= '0;
      dir_q <= DIR_READ;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= obi_gnt_o ? dir_e'(obi_we_i) : dir_q;
      rvalid_q <= rsp_hs;
      rdata_q <= r_hs ? axi_resp_i.r.data : '0;
      err_q <= r_hs ? axi_resp_i.r.resp[1] : (b_hs & axi_resp_i.b.resp[1]);
    end
  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni) rsp_hs |-> cnt_q != '0);
endmodule

// File: tb/tb_obi_axi_bridge.sv
// tb_obi_axi_bridge: table vectors plus corner sequences, responses checked through a scoreboard
module tb_obi_axi_bridge;
  import obi_axi_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic req, gnt, we, rvalid, err;
  logic [3:0] be;
  logic [31:0] addr, wdata, rdata;
  axi_32_req_t axi_req;
  axi_32_resp_t axi_resp;
  int n_chk = 0;
  int n_fail = 0;
  int aw_cnt = 0;
  int w_cnt = 0;
  typedef struct {
    logic we;
    logic [31:0] addr;
    logic [3:0] be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0] resp;
    logic [31:0] exp_rdata;
    logic exp_err;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    logic err;
  } rsp_t;
  rsp_t sb[$];
  vec_t vecs[6];

  obi_axi_bridge dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .obi_req_i(req),
    .obi_gnt_o(gnt),
    .obi_we_i(we),
    .obi_be_i(be),
    .obi_addr_i(addr),
    .obi_wdata_i(wdata),
    .obi_rvalid_o(rvalid),
    .obi_rdata_o(rdata),
    .obi_err_o(err),
    .axi_req_o(axi_req),
    .axi_resp_i(axi_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    rsp_t r;
    r.rdata = d;
    r.err = e;
    sb.push_back(r);
  endtask

  always @(negedge clk) begin
    if (rst_n && axi_req.aw_valid && axi_resp.aw_ready) aw_cnt++;
    if (rst_n && axi_req.w_valid && axi_resp.w_ready) w_cnt++;
    if (rst_n && rvalid) begin
      if (sb.size() == 0) chk("unexpected_rvalid", 64'(rvalid), 64'd0);
      else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", 64'(rdata), 64'(e.rdata));
        chk("rsp_err", 64'(err), 64'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_txn(input vec_t v);
    bit got;
    step();
    req = 1'b1;
    we = v.we;
    addr = v.addr;
    be = v.be;
    wdata = v.wdata;
    axi_resp.ar_ready = 1'b1;
    axi_resp.aw_ready = 1'b1;
    axi_resp.w_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = gnt;
      if (!got) step();
    end
    chk("txn_gnt", 64'(got), 64'd1);
    if (v.we) begin
      chk("aw_addr", 64'(axi_req.aw.addr), 64'(v.addr));
      chk("w_data", 64'(axi_req.w.data), 64'(v.wdata));
      chk("w_strb", 64'(axi_req.w.strb), 64'(v.be));
      chk("w_last", 64'(axi_req.w.last), 64'd1);
    end else begin
      chk("ar_addr", 64'(axi_req.ar.addr), 64'(v.addr));
      chk("ar_size", 64'(axi_req.ar.size), 64'd2);
      chk("ar_len", 64'(axi_req.ar.len), 64'd0);
      chk("ar_burst", 64'(axi_req.ar.burst), 64'(BURST_INCR));
    end
    step();
    req = 1'b0;
    if (v.we) begin
      axi_resp.b_valid = 1'b1;
      axi_resp.b.resp = v.resp;
    end else begin
      axi_resp.r_valid = 1'b1;
      axi_resp.r.data = v.rdata;
      axi_resp.r.resp = v.resp;
    end
    push(v.exp_rdata, v.exp_err);
    step();
    axi_resp.r_valid = 1'b0;
    axi_resp.b_valid = 1'b0;
    idle(2);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h1000, 4'hF, 32'h0, 32'hDEADBEEF, RESP_OKAY, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h1004, 4'hF, 32'h12345678, 32'h0, RESP_OKAY, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 32'h1008, 4'h3, 32'hA5A5A5A5, 32'h0, RESP_SLVERR, 32'h0, 1'b1};
    vecs[3] = '{1'b1, 32'h100C, 4'h1, 32'h0BADF00D, 32'h0, RESP_EXOKAY, 32'h0, 1'b0};
    vecs[4] = '{1'b0, 32'h2000, 4'hF, 32'h0, 32'hCAFEF00D, RESP_DECERR, 32'hCAFEF00D, 1'b1};
    vecs[5] = '{1'b0, 32'h2004, 4'hF, 32'h0, 32'h00005A5A, RESP_EXOKAY, 32'h00005A5A, 1'b0};
    rst_n = 1'b0;
    req = 1'b0;
    we = 1'b0;
    be = 4'h0;
    addr = '0;
    wdata = '0;
    axi_resp = '0;
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_valids", 64'({axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid}), 64'd0);
    chk("rst_cnt", 64'(dut.cnt_q), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) do_txn(vecs[i]);
    chk("table_sb_empty", 64'(sb.size()), 64'd0);

    // split write: AW accepted at once, W held off for three cycles
    step();
    req = 1'b1;
    we = 1'b1;
    addr = 32'h4000;
    be = 4'b0011;
    wdata = 32'h11223344;
    axi_resp.aw_ready = 1'b1;
    axi_resp.w_ready = 1'b0;
    aw_cnt = 0;
    w_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) axi_resp.w_ready = 1'b1;
      @(negedge clk);
      chk("split_gnt", 64'(gnt), 64'(k == 3));
      chk("split_aw_valid", 64'(axi_req.aw_valid), 64'(k == 0));
      chk("split_w_valid", 64'(axi_req.w_valid), 64'd1);
      chk("split_strb", 64'(axi_req.w.strb), 64'h3);
      step();
    end
    req = 1'b0;
    idle(2);
    chk("split_aw_count", 64'(aw_cnt), 64'd1);
    chk("split_w_count", 64'(w_cnt), 64'd1);
    axi_resp.b_valid = 1'b1;
    axi_resp.b.resp = RESP_OKAY;
    push(32'h0, 1'b0);
    step();
    axi_resp.b_valid = 1'b0;
    idle(2);

    // outstanding limit: reads stall at four until an R beat frees a slot
    req = 1'b1;
    we = 1'b0;
    addr = 32'h2000;
    axi_resp.ar_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("lim_gnt", 64'(gnt), 64'(k < 4));
      if (k >= 4) chk("lim_ar_valid", 64'(axi_req.ar_valid), 64'd0);
      step();
    end
    chk("lim_cnt_full", 64'(dut.cnt_q), 64'd4);
    axi_resp.r_valid = 1'b1;
    axi_resp.r.data = 32'hA0;
    axi_resp.r.resp = RESP_OKAY;
    push(32'hA0, 1'b0);
    @(negedge clk);
    chk("lim_gnt_beat_cycle", 64'(gnt), 64'd0);
    step();
    axi_resp.r_valid = 1'b0;
    @(negedge clk);
    chk("lim_gnt_after_beat", 64'(gnt), 64'd1);
    chk("lim_cnt_dip", 64'(dut.cnt_q), 64'd3);
    step();
    req = 1'b0;
    @(negedge clk);
    chk("lim_cnt_back", 64'(dut.cnt_q), 64'd4);
    step();
    for (int i = 0; i < 4; i++) begin
      axi_resp.r_valid = 1'b1;
      axi_resp.r.data = 32'hB0 + 32'(i);
      push(32'hB0 + 32'(i), 1'b0);
      step();
    end
    axi_resp.r_valid = 1'b0;
    idle(2);
    chk("lim_cnt_drained", 64'(dut.cnt_q), 64'd0);

    // direction change: a write waits for both reads to drain
    req = 1'b1;
    we = 1'b0;
    addr = 32'h3000;
    @(negedge clk);
    chk("dir_rd_gnt0", 64'(gnt), 64'd1);
    step();
    @(negedge clk);
    chk("dir_rd_gnt1", 64'(gnt), 64'd1);
    step();
    we = 1'b1;
    addr = 32'h3004;
    be = 4'hF;
    wdata = 32'h77778888;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("dir_wait_aw", 64'(axi_req.aw_valid), 64'd0);
      chk("dir_wait_gnt", 64'(gnt), 64'd0);
      step();
    end
    axi_resp.r_valid = 1'b1;
    axi_resp.r.data = 32'h11;
    push(32'h11, 1'b0);
    @(negedge clk);
    chk("dir_wait_aw_r1", 64'(axi_req.aw_valid), 64'd0);
    step();
    axi_resp.r.data = 32'h22;
    push(32'h22, 1'b0);
    @(negedge clk);
    chk("dir_wait_aw_r2", 64'(axi_req.aw_valid), 64'd0);
    step();
    axi_resp.r_valid = 1'b0;
    @(negedge clk);
    chk("dir_aw_go", 64'(axi_req.aw_valid), 64'd1);
    chk("dir_wr_gnt", 64'(gnt), 64'd1);
    step();
    req = 1'b0;
    axi_resp.b_valid = 1'b1;
    axi_resp.b.resp = RESP_OKAY;
    push(32'h0, 1'b0);
    step();
    axi_resp.b_valid = 1'b0;
    idle(2);
    chk("dir_sb_empty", 64'(sb.size()), 64'd0);

    // reset in the middle of a partially accepted write
    req = 1'b1;
    we = 1'b1;
    addr = 32'h5000;
    axi_resp.aw_ready = 1'b1;
    axi_resp.w_ready = 1'b1;
    step();
    step();
    axi_resp.w_ready = 1'b0;
    step();
    @(negedge clk);
    chk("mid_aw_done", 64'(dut.u_wr.aw_done_q), 64'd1);
    chk("mid_cnt", 64'(dut.cnt_q), 64'd2);
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    chk("mid_rst_cnt", 64'(dut.cnt_q), 64'd0);
    chk("mid_rst_aw_done", 64'(dut.u_wr.aw_done_q), 64'd0);
    chk("mid_rst_outs", 64'({gnt, rvalid, err, axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid}), 64'd0);
    chk("mid_rst_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    axi_resp.w_ready = 1'b1;
    do_txn('{1'b0, 32'h6000, 4'hF, 32'h0, 32'h600DCAFE, RESP_OKAY, 32'h600DCAFE, 1'b0});
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
